// File: rtl/gbvga_pkg.sv
// Shared constants and types for the Game Boy capture / VGA scan-out framebuffer path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gbvga_pkg;

    // Framebuffer geometry. The scan-out side uses H_PIX as its line stride.
    localparam int unsigned H_PIX     = 160;
    localparam int unsigned V_PIX     = 144;
    localparam int unsigned FB_ADDR_W = 15;   // holds H_PIX*V_PIX-1 = 23039

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        CAPTURE    = 1'b1
    } capture_state_t;

endpackage

// File: rtl/gb_sync_edge.sv
// Two-flop synchroniser with a third stage giving registered rise/fall strobes.
// Latency: level valid 2 clk after the pin, rise/fall strobes 3 clk after the pin.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
//
// Ports:
//   clk, reset_n : clock and async active-low reset
//   din          : asynchronous inputs
//   level        : synchronised level (second flop)
//   rise, fall   : one-cycle edge strobes, registered
module gb_sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            s3   <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign level = s2;

endmodule

// File: rtl/gb_capture_ctrl.sv
// Captures Game Boy LCD pixels into the 2bpp framebuffer at address row*H_PIX+col.
// Latency: GB pin edge to wren is 4 clk (2 sync, edge register, write register).
// Backpressure: none; clk must run >= 4x gb_cp so at most one pixel is in flight.
//
// Ports:
//   clk, reset_n            : clock and async active-low reset
//   enable                  : capture enable, low forces WAIT_FRAME; rising edge clears errors
//   gb_cp/gb_hs/gb_vs/gb_d  : asynchronous GB LCD pins
//   wraddress/wrdata/wren   : framebuffer write port, wren is a one-cycle strobe
//   frame_done              : one-cycle pulse when the last line of a frame completes
//   in_frame                : high while in CAPTURE
//   err_overflow            : sticky, pixel arrived beyond the line or frame
//   err_short_line          : sticky, line latch with a column count other than H_PIX
module gb_capture_ctrl #(
    parameter int unsigned H_PIX  = gbvga_pkg::H_PIX,
    parameter int unsigned V_PIX  = gbvga_pkg::V_PIX,
    parameter int unsigned ADDR_W = gbvga_pkg::FB_ADDR_W,
    parameter bit          INVERT = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              gb_cp,
    input  logic              gb_hs,
    input  logic              gb_vs,
    input  logic [1:0]        gb_d,
    output logic [ADDR_W-1:0] wraddress,
    output logic [1:0]        wrdata,
    output logic              wren,
    output logic              frame_done,
    output logic              in_frame,
    output logic              err_overflow,
    output logic              err_short_line
);

    import gbvga_pkg::*;

    localparam logic [7:0]        H_LIM  = 8'(H_PIX);
    localparam logic [7:0]        V_LIM  = 8'(V_PIX);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIX);

    // Control pins share one synchroniser: bit 0 = cp, 1 = hs, 2 = vs.
    logic [2:0] ctl_lvl;
    logic [2:0] ctl_rise;
    logic [2:0] ctl_fall;
    logic [1:0] d_lvl;
    logic [1:0] d_rise;
    logic [1:0] d_fall;

    gb_sync_edge #(.W(3)) u_sync_ctl (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({gb_vs, gb_hs, gb_cp}),
        .level   (ctl_lvl),
        .rise    (ctl_rise),
        .fall    (ctl_fall)
    );

    gb_sync_edge #(.W(2)) u_sync_d (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (gb_d),
        .level   (d_lvl),
        .rise    (d_rise),
        .fall    (d_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{ctl_lvl[1:0], ctl_rise[2], ctl_rise[0], ctl_fall[2:1], d_rise, d_fall};

    logic cp_fall;
    logic hs_rise;
    logic vs_lvl;
    assign cp_fall = ctl_fall[0];
    assign hs_rise = ctl_rise[1];
    assign vs_lvl  = ctl_lvl[2];

    capture_state_t    state;
    logic [7:0]        col;
    logic [7:0]        row;
    logic [ADDR_W-1:0] row_base;
    logic [1:0]        d_s3;      // data stage aligned with the cp edge strobe
    logic              en_q;

    logic       pix_ok;
    logic [7:0] col_inc;
    logic [7:0] col_after;
    logic [7:0] row_inc;

    assign pix_ok  = (col < H_LIM) && (row < V_LIM);
    assign col_inc = col + 8'd1;
    assign row_inc = row + 8'd1;
    // A pixel landing in the same cycle as the line latch still counts toward the line.
    assign col_after = (cp_fall && pix_ok) ? col_inc : col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= WAIT_FRAME;
            col            <= '0;
            row            <= '0;
            row_base       <= '0;
            wraddress      <= '0;
            wrdata         <= '0;
            wren           <= 1'b0;
            frame_done     <= 1'b0;
            in_frame       <= 1'b0;
            err_overflow   <= 1'b0;
            err_short_line <= 1'b0;
            en_q           <= 1'b0;
            d_s3           <= '0;
        end else begin
            wren       <= 1'b0;
            frame_done <= 1'b0;
            en_q       <= enable;
            d_s3       <= d_lvl;

            // New capture session starts with clean error flags.
            if (enable && !en_q) begin
                err_overflow   <= 1'b0;
                err_short_line <= 1'b0;
            end

            if (!enable) begin
                state    <= WAIT_FRAME;
                in_frame <= 1'b0;
            end else begin
                case (state)
                    WAIT_FRAME: begin
                        if (hs_rise && vs_lvl) begin
                            col      <= '0;
                            row      <= '0;
                            row_base <= '0;
                            state    <= CAPTURE;
                            in_frame <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (cp_fall) begin
                            if (pix_ok) begin
                                wren      <= 1'b1;
                                wraddress <= row_base + ADDR_W'(col);
                                wrdata    <= d_s3 ^ {2{INVERT}};
                                col       <= col_inc;
                            end else begin
                                err_overflow <= 1'b1;
                            end
                        end
                        if (hs_rise) begin
                            col <= '0;
                            if (col_after != H_LIM) begin
                                err_short_line <= 1'b1;
                            end
                            if (vs_lvl) begin
                                // Frame marker seen mid-frame: restart at the top, no frame_done.
                                row            <= '0;
                                row_base       <= '0;
                                err_short_line <= 1'b1;
                            end else begin
                                row      <= row_inc;
                                row_base <= row_base + H_STEP;
                                if (row_inc == V_LIM) begin
                                    frame_done <= 1'b1;
                                    state      <= WAIT_FRAME;
                                    in_frame   <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state    <= WAIT_FRAME;
                        in_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gb_capture_ctrl.sv
// Self-checking bench for gb_capture_ctrl with a reduced frame height.
// Expected framebuffer writes are queued when pixels are driven and popped on wren.
module tb_gb_capture_ctrl;

    localparam int H = 160;
    localparam int V = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        gb_cp;
    logic        gb_hs;
    logic        gb_vs;
    logic [1:0]  gb_d;
    logic [14:0] wraddress;
    logic [1:0]  wrdata;
    logic        wren;
    logic        frame_done;
    logic        in_frame;
    logic        err_overflow;
    logic        err_short_line;

    gb_capture_ctrl #(
        .H_PIX  (H),
        .V_PIX  (V),
        .ADDR_W (15),
        .INVERT (1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .gb_cp          (gb_cp),
        .gb_hs          (gb_hs),
        .gb_vs          (gb_vs),
        .gb_d           (gb_d),
        .wraddress      (wraddress),
        .wrdata         (wrdata),
        .wren           (wren),
        .frame_done     (frame_done),
        .in_frame       (in_frame),
        .err_overflow   (err_overflow),
        .err_short_line (err_short_line)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int fd_cnt  = 0;
    logic prev_wren = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_e;

    // Reference model of the write sequencer.
    int m_row = 0;
    int m_col = 0;
    bit m_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_line(input bit vs);
        if (vs) begin
            m_active = 1'b1;
            m_row    = 0;
            m_col    = 0;
        end else if (m_active) begin
            m_col = 0;
            m_row++;
            if (m_row == V) m_active = 1'b0;
        end
    endtask

    task automatic model_pixel(input logic [1:0] d, input bit hs_too);
        logic [1:0] inv;
        inv = ~d;
        if (m_active && m_col < H && m_row < V) begin
            exp_q.push_back({15'(m_row * H + m_col), inv});
            m_col++;
        end
        if (hs_too) model_line(1'b0);
    endtask

    // One pixel: data set up, cp falls (optionally together with hs rising),
    // lat = clk edges from the pin edge until wren is seen (0 if never).
    task automatic pixel(input logic [1:0] d, input bit hs_too, output int lat);
        model_pixel(d, hs_too);
        @(posedge clk); #1;
        gb_d = d;
        @(posedge clk); #1;
        gb_cp = 1'b0;
        if (hs_too) gb_hs = 1'b1;
        lat = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (wren && lat == 0) lat = k;
        end
        gb_cp = 1'b1;
        gb_hs = 1'b0;
    endtask

    task automatic hs_line(input bit vs, output int fd_lat);
        model_line(vs);
        @(posedge clk); #1;
        gb_vs = vs;
        gb_hs = 1'b1;
        fd_lat = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_done && fd_lat == 0) fd_lat = k;
        end
        gb_hs = 1'b0;
        gb_vs = 1'b0;
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wren) begin
                wr_cnt++;
                check("wren_gap", prev_wren, 1'b0);
                check("write_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check("wraddress", wraddress, exp_e[16:2]);
                    check("wrdata", wrdata, exp_e[1:0]);
                end
            end
            if (frame_done) fd_cnt++;
        end
        prev_wren = wren;
    end

    initial begin
        int lat;
        int fd;
        bit seen;

        reset_n = 1'b0;
        enable  = 1'b0;
        gb_cp   = 1'b1;
        gb_hs   = 1'b0;
        gb_vs   = 1'b0;
        gb_d    = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wren", wren, 1'b0);
        check("rst_wraddress", wraddress, 15'd0);
        check("rst_wrdata", wrdata, 2'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_in_frame", in_frame, 1'b0);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_err_short_line", err_short_line, 1'b0);

        @(posedge clk); #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (3) @(posedge clk);

        // Full frame, gb_d = row[1:0].
        hs_line(1'b1, fd);
        check("in_frame_start", in_frame, 1'b1);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) pixel(2'(r), 1'b0, lat);
            hs_line(1'b0, fd);
            if (r == V - 1) check("frame_done_latency", fd, 4);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("frame_write_count", wr_cnt, H * V);
        check("frame_done_count", fd_cnt, 1);
        check("frame_in_frame_after", in_frame, 1'b0);
        check("frame_err_overflow", err_overflow, 1'b0);
        check("frame_err_short_line", err_short_line, 1'b0);
        check("frame_queue_drained", exp_q.size(), 0);

        // Second frame: latency, simultaneous edge, short line, overflow.
        hs_line(1'b1, fd);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < H; c++) pixel(2'(r), 1'b0, lat);
            hs_line(1'b0, fd);
        end
        for (int c = 0; c < 5; c++) pixel(2'(c), 1'b0, lat);
        pixel(2'b01, 1'b0, lat);
        check("pix_latency", lat, 4);
        check("pix_addr_r3c5", wraddress, 15'd485);
        check("pix_data_inverted", wrdata, 2'b10);
        for (int c = 6; c < H - 1; c++) pixel(2'(c), 1'b0, lat);
        pixel(2'b11, 1'b1, lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("simul_addr", wraddress, 15'(3 * H + H - 1));
        check("simul_err_short_line", err_short_line, 1'b0);
        check("simul_err_overflow", err_overflow, 1'b0);

        for (int c = 0; c < 150; c++) pixel(2'(c), 1'b0, lat);
        hs_line(1'b0, fd);
        check("short_line_flag", err_short_line, 1'b1);
        check("short_line_in_frame", in_frame, 1'b1);

        for (int c = 0; c < H; c++) pixel(2'(c), 1'b0, lat);
        check("ovf_before_161", err_overflow, 1'b0);
        pixel(2'b00, 1'b0, lat);
        check("ovf_on_161", err_overflow, 1'b1);
        check("ovf_no_write", lat, 0);
        for (int c = 0; c < 4; c++) pixel(2'(c), 1'b0, lat);
        check("ovf_last_addr", wraddress, 15'(5 * H + H - 1));
        hs_line(1'b0, fd);
        check("short_line_sticky", err_short_line, 1'b1);

        // Drop enable while a pixel is in the synchroniser.
        for (int c = 0; c < 3; c++) pixel(2'(c), 1'b0, lat);
        @(posedge clk); #1;
        gb_d = 2'b01;
        @(posedge clk); #1;
        gb_cp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable   = 1'b0;
        m_active = 1'b0;
        seen     = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wren) seen = 1'b1;
        end
        gb_cp = 1'b1;
        check("disable_no_wren", seen, 1'b0);
        check("disable_in_frame", in_frame, 1'b0);
        check("disable_no_frame_done", fd_cnt, 1);
        check("disable_err_held", {err_overflow, err_short_line}, 2'b11);
        check("disable_queue_drained", exp_q.size(), 0);

        @(posedge clk); #1;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reenable_errs_clear", {err_overflow, err_short_line}, 2'b00);

        // Third frame, then async reset while wren is high.
        hs_line(1'b1, fd);
        for (int c = 0; c < 2; c++) pixel(2'(c), 1'b0, lat);
        @(posedge clk); #1;
        gb_d = 2'b10;
        @(posedge clk); #1;
        gb_cp = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (wren) seen = 1'b1;
            end
        end
        check("midwrite_wren_seen", seen, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_wren", wren, 1'b0);
        check("arst_wraddress", wraddress, 15'd0);
        check("arst_wrdata", wrdata, 2'd0);
        check("arst_in_frame", in_frame, 1'b0);
        check("arst_frame_done", frame_done, 1'b0);
        gb_cp = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);
        check("final_frame_done_count", fd_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
